apb_rr_arbiter: RTL and testbench

- Sequences APB transfers from NCORES core-side masters onto one shared downstream APB slave port, e.g. a cluster's shared data or instruction memory.
- Grants one master at a time under round-robin priority.
- Latches the granted master's request and replays it as a clean SETUP/ACCESS pair on the slave side.
- Returns PRDATA/PREADY to the granted master only.

---
 rtl/apb_rr_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_rr_arbiter: round-robin arbiter folding N APB masters onto one slave |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module apb_rr_arbiter #(
  parameter int MASTER_PORTS = 4,
  parameter int BUS_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic                               M_PSELx,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [DATA_WIDTH-1:0]              M_PRDATA,
  input  logic                               M_PREADY,
  output logic [$clog2(MASTER_PORTS)-1:0]    grant_id,
  output logic                               busy
);

  localparam int              c_IDW    = $clog2(MASTER_PORTS);
  localparam logic [c_IDW:0]  c_NPORTS = (c_IDW + 1)'(MASTER_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;

  logic [c_IDW-1:0]                  r_rr_ptr;
  logic [c_IDW-1:0]                  r_grant_id;
  logic [BUS_WIDTH-1:0]              r_m_paddr;
  logic                              r_m_pwrite;
  logic                              r_m_psel;
  logic                              r_m_penable;
  logic [DATA_WIDTH-1:0]             r_m_pwdata;
  logic [MASTER_PORTS-1:0]           r_s_pready;
  logic [MASTER_PORTS*DATA_WIDTH-1:0] r_s_prdata;

  logic [2*MASTER_PORTS-1:0]         w_req_shift;
  logic [MASTER_PORTS-1:0]           w_req_rot;
  logic [c_IDW-1:0]                  w_off;
  logic [c_IDW:0]                    w_pick_sum;
  logic [c_IDW:0]                    w_pick_wrap;
  logic [c_IDW-1:0]                  w_pick;
  logic [c_IDW:0]                    w_rr_sum;
  logic [c_IDW-1:0]                  w_rr_nxt;
  logic [BUS_WIDTH-1:0]              w_sel_paddr;
  logic                              w_sel_pwrite;
  logic [DATA_WIDTH-1:0]             w_sel_pwdata;
  logic [MASTER_PORTS-1:0]           w_grant_onehot;
  logic [MASTER_PORTS*DATA_WIDTH-1:0] w_prdata_upd;
  logic                              w_unused_penable;

  assign w_unused_penable = ^S_PENABLE;

  // Rotate requests so bit 0 is the current priority holder, then take the
  // lowest set bit as an offset from rr_ptr.
  assign w_req_shift = {S_PSELx, S_PSELx} >> r_rr_ptr;
  assign w_req_rot   = w_req_shift[MASTER_PORTS-1:0];

  always_comb begin
    w_off = '0;
    for (int k = MASTER_PORTS - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_off = k[c_IDW-1:0];
      end
    end
  end

  assign w_pick_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_pick_wrap = w_pick_sum - c_NPORTS;
  assign w_pick      = (w_pick_sum >= c_NPORTS) ? w_pick_wrap[c_IDW-1:0]
                                                : w_pick_sum[c_IDW-1:0];

  assign w_rr_sum = {1'b0, r_grant_id} + (c_IDW + 1)'(1);
  assign w_rr_nxt = (w_rr_sum >= c_NPORTS) ? '0 : w_rr_sum[c_IDW-1:0];

  always_comb begin
    w_sel_paddr  = '0;
    w_sel_pwrite = 1'b0;
    w_sel_pwdata = '0;
    for (int i = 0; i < MASTER_PORTS; i++) begin
      if (w_pick == i[c_IDW-1:0]) begin
        w_sel_paddr  = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
        w_sel_pwrite = S_PWRITE[i];
        w_sel_pwdata = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_grant_onehot = '0;
    w_prdata_upd   = r_s_prdata;
    for (int i = 0; i < MASTER_PORTS; i++) begin
      if (r_grant_id == i[c_IDW-1:0]) begin
        w_grant_onehot[i]                        = 1'b1;
        w_prdata_upd[i*DATA_WIDTH +: DATA_WIDTH] = M_PRDATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (|S_PSELx) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (M_PREADY) w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are captured once at grant; the slave only ever sees the
  // latched copy, so a master fiddling with its bus after grant is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_m_paddr   <= '0;
      r_m_pwrite  <= 1'b0;
      r_m_psel    <= 1'b0;
      r_m_penable <= 1'b0;
      r_m_pwdata  <= '0;
      r_s_pready  <= '0;
      r_s_prdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|S_PSELx) begin
            r_m_paddr  <= w_sel_paddr;
            r_m_pwrite <= w_sel_pwrite;
            r_m_pwdata <= w_sel_pwdata;
            r_grant_id <= w_pick;
            r_m_psel   <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_m_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (M_PREADY) begin
            r_m_psel    <= 1'b0;
            r_m_penable <= 1'b0;
            r_rr_ptr    <= w_rr_nxt;
            r_s_pready  <= w_grant_onehot;
            if (!r_m_pwrite) begin
              r_s_prdata <= w_prdata_upd;
            end
          end
        end
        ST_RESP: begin
          r_s_pready <= '0;
        end
        default: begin
          r_s_pready <= '0;
        end
      endcase
    end
  end

  assign M_PADDR   = r_m_paddr;
  assign M_PWRITE  = r_m_pwrite;
  assign M_PSELx   = r_m_psel;
  assign M_PENABLE = r_m_penable;
  assign M_PWDATA  = r_m_pwdata;
  assign S_PREADY  = r_s_pready;
  assign S_PRDATA  = r_s_prdata;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// Bench for apb_rr_arbiter: master agents, slave responder and a response
// scoreboard driven by directed transfers.
module tb_apb_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] S_PADDR;
  logic [3:0]  S_PWRITE;
  logic [3:0]  S_PSELx;
  logic [3:0]  S_PENABLE;
  logic [63:0] S_PWDATA;
  logic [63:0] S_PRDATA;
  logic [3:0]  S_PREADY;
  logic [15:0] M_PADDR;
  logic        M_PWRITE;
  logic        M_PSELx;
  logic        M_PENABLE;
  logic [15:0] M_PWDATA;
  logic [15:0] M_PRDATA;
  logic        M_PREADY;
  logic [1:0]  grant_id;
  logic        busy;

  apb_rr_arbiter #(.MASTER_PORTS(4), .BUS_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
    .S_PREADY(S_PREADY),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
    .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA),
    .M_PREADY(M_PREADY), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr; logic wr; logic [15:0] wdata; logic alt_en; logic [15:0] alt_addr;
  } mreq_t;
  typedef struct packed {
    logic [15:0] addr; logic wr; logic [15:0] wdata; logic [15:0] rdata; logic [7:0] waits;
  } sreq_t;
  typedef struct packed {
    logic [1:0] m; logic wr; logic [15:0] rdata;
  } eresp_t;

  mreq_t       mq [4][$];
  sreq_t       sq [$];
  eresp_t      eq [$];
  logic [15:0] shadow [4] = '{default: 16'h0};
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_rdy_cyc = -10;
  int          acc = 0;
  eresp_t      mon_e;
  int          mon_i;
  int          n_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=missing/unexpected required=expected-event (t=%0t)", name, $time);
  endtask

  task automatic issue(input int m, input logic [15:0] addr, input logic wr,
                       input logic [15:0] wdata, input logic [15:0] rdata, input int waits,
                       input bit resp = 1'b1, input bit alt_en = 1'b0,
                       input logic [15:0] alt = 16'h0);
    mreq_t  mr;
    sreq_t  sr;
    eresp_t er;
    mr = '{addr: addr, wr: wr, wdata: wdata, alt_en: alt_en, alt_addr: alt};
    sr = '{addr: addr, wr: wr, wdata: wdata, rdata: rdata, waits: 8'(waits)};
    er = '{m: 2'(m), wr: wr, rdata: rdata};
    mq[m].push_back(mr);
    sq.push_back(sr);
    if (resp) eq.push_back(er);
  endtask

  task automatic wait_drain(input int max_cyc, output int n_access);
    bit done;
    done = 1'b0;
    n_access = 0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      @(negedge clk);
      if (M_PENABLE) n_access++;
      if (eq.size() == 0 && sq.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) flag("drain_timeout");
  endtask

  // Master agents: hold a request until S_PREADY, then drop or load the next one.
  initial begin
    S_PADDR = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0; S_PWDATA = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (reset) begin
          S_PSELx[i]   = 1'b0;
          S_PENABLE[i] = 1'b0;
        end else begin
          if (S_PREADY[i] && mq[i].size() > 0) void'(mq[i].pop_front());
          if (S_PREADY[i] || !S_PSELx[i]) begin
            if (mq[i].size() > 0) begin
              S_PADDR[i*16 +: 16]  = mq[i][0].addr;
              S_PWDATA[i*16 +: 16] = mq[i][0].wdata;
              S_PWRITE[i]          = mq[i][0].wr;
              S_PSELx[i]           = 1'b1;
              S_PENABLE[i]         = 1'b1;
            end else begin
              S_PSELx[i]   = 1'b0;
              S_PENABLE[i] = 1'b0;
            end
          end else if (M_PSELx && !M_PENABLE && grant_id == 2'(i) &&
                       mq[i].size() > 0 && mq[i][0].alt_en) begin
            S_PADDR[i*16 +: 16] = mq[i][0].alt_addr;
          end
        end
      end
    end
  end

  // Slave responder: checks the presented transfer every ACCESS cycle.
  initial begin
    M_PREADY = 1'b0;
    M_PRDATA = '0;
    forever begin
      @(negedge clk);
      M_PREADY = 1'b0;
      if (M_PSELx && M_PENABLE) begin
        if (sq.size() == 0) begin
          flag("slave_unexpected_access");
          M_PREADY = 1'b1;
        end else begin
          chk("m_paddr", 32'(M_PADDR), 32'(sq[0].addr));
          chk("m_pwrite", 32'(M_PWRITE), 32'(sq[0].wr));
          chk("m_pwdata", 32'(M_PWDATA), 32'(sq[0].wdata));
          if (acc >= int'(sq[0].waits)) begin
            M_PREADY     = 1'b1;
            M_PRDATA     = sq[0].rdata;
            last_rdy_cyc = cyc;
            void'(sq.pop_front());
            acc = 0;
          end else begin
            acc++;
          end
        end
      end else begin
        acc = 0;
      end
    end
  end

  // Response monitor: pops an expected completion for every S_PREADY pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (S_PREADY != 4'b0000) begin
        if (eq.size() == 0) begin
          flag("unexpected_pready");
        end else begin
          mon_e = eq.pop_front();
          mon_i = int'(mon_e.m);
          chk("pready_onehot", 32'(S_PREADY), 32'(4'b0001 << mon_e.m));
          if (!mon_e.wr) shadow[mon_i] = mon_e.rdata;
          chk("prdata_slice", 32'(S_PRDATA[mon_i*16 +: 16]), 32'(shadow[mon_i]));
          chk("resp_latency", 32'(cyc), 32'(last_rdy_cyc + 1));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit found;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_psel", 32'(M_PSELx), 32'd0);
    chk("rst_m_penable", 32'(M_PENABLE), 32'd0);
    chk("rst_m_paddr", 32'(M_PADDR), 32'd0);
    chk("rst_m_pwdata", 32'(M_PWDATA), 32'd0);
    chk("rst_m_pwrite", 32'(M_PWRITE), 32'd0);
    chk("rst_s_pready", 32'(S_PREADY), 32'd0);
    chk("rst_s_prdata_any", 32'(|S_PRDATA), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single read from master 2, zero waits: exact cycle profile.
    @(posedge clk); #1 issue(2, 16'h0040, 1'b0, 16'h0000, 16'hBEEF, 0);
    @(negedge clk);
    chk("t1_idle_psel", 32'(M_PSELx), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_setup_psel", 32'(M_PSELx), 32'd1);
    chk("t1_setup_penable", 32'(M_PENABLE), 32'd0);
    chk("t1_setup_busy", 32'(busy), 32'd1);
    chk("t1_grant", 32'(grant_id), 32'd2);
    @(negedge clk);
    chk("t1_access_psel", 32'(M_PSELx), 32'd1);
    chk("t1_access_penable", 32'(M_PENABLE), 32'd1);
    chk("t1_access_pready", 32'(S_PREADY), 32'd0);
    @(negedge clk);
    chk("t1_resp_pready", 32'(S_PREADY), 32'h4);
    chk("t1_resp_psel", 32'(M_PSELx), 32'd0);
    chk("t1_resp_prdata", 32'(S_PRDATA[32 +: 16]), 32'hBEEF);
    wait_drain(50, n_acc);

    // rr_ptr=3 with masters 0 and 3: 3 first, then wrap to 0.
    @(posedge clk); #1;
    issue(3, 16'h0300, 1'b0, 16'h0000, 16'h3333, 0);
    issue(0, 16'h0004, 1'b0, 16'h0000, 16'hA0A0, 1);
    wait_drain(60, n_acc);
    chk("t4_last_grant", 32'(grant_id), 32'd0);

    // Master 1 write with three slave wait states.
    @(posedge clk); #1 issue(1, 16'h0010, 1'b1, 16'h1234, 16'hDEAD, 3);
    wait_drain(60, n_acc);
    chk("t3_access_cycles", 32'(n_acc), 32'd4);
    chk("t3_prdata1_kept", 32'(S_PRDATA[16 +: 16]), 32'h0000);

    // Master 0 moves its address during SETUP; the latched 0x0020 must stick.
    @(posedge clk); #1 issue(0, 16'h0020, 1'b0, 16'h0000, 16'h5A5A, 1, 1'b1, 1'b1, 16'h0030);
    wait_drain(60, n_acc);
    chk("t6_access_cycles", 32'(n_acc), 32'd2);

    // Reset on the second ACCESS wait cycle of a long transfer from master 2.
    @(posedge clk); #1 issue(2, 16'h0050, 1'b0, 16'h0000, 16'h7777, 5, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (M_PENABLE) found = 1'b1;
    end
    if (!found) flag("t5_access_timeout");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    mq[2].delete();
    sq.delete();
    @(negedge clk);
    chk("t5_psel", 32'(M_PSELx), 32'd0);
    chk("t5_penable", 32'(M_PENABLE), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_pready", 32'(S_PREADY), 32'd0);
    chk("t5_grant", 32'(grant_id), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t5_no_pulse", 32'(S_PREADY), 32'd0);
    end

    // All four masters request twice each; rr_ptr is 0 again after reset.
    @(posedge clk); #1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) begin
        issue(i, 16'(16'h0100 + i*16 + rep), 1'b0, 16'(16'h00F0 + i),
              16'(16'hC000 + rep*16 + i), (i + rep) % 2);
      end
    end
    wait_drain(200, n_acc);
    chk("t2_access_cycles", 32'(n_acc), 32'd12);
    chk("t2_last_grant", 32'(grant_id), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("final_prdata", 32'(S_PRDATA[i*16 +: 16]), 32'(16'hC010 + i));
    end
    chk("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
